// File: rtl/rpm_pkg.sv
// rtl/rpm_pkg.sv - shared defaults, sum-width rule and period type for the tooth-period averager
package rpm_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_LOG2_DEPTH   = 3;
    localparam int DEF_SUM_WIDTH    = 19;
    localparam int DEF_REJECT_LIMIT = 3;

    typedef logic [DEF_WIDTH-1:0] period_t;

    // Smallest running-sum width that can hold DEPTH full-scale periods without overflow
    function automatic int min_sum_width(input int width, input int log2_depth);
        return width + $clog2(2 ** log2_depth);
    endfunction

endpackage

// File: rtl/rpm_avg_ring.sv
// rtl/rpm_avg_ring.sv - DEPTH x WIDTH period ring with write pointer and oldest-sample read port
module rpm_avg_ring
    import rpm_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             we,
    input  logic             restart,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] oldest
);

    localparam int DEPTH = 1 << LOG2_DEPTH;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wptr;
    logic [LOG2_DEPTH-1:0] waddr;

    // A restart always lands the new sample in slot 0
    assign waddr  = restart ? '0 : wptr;
    // The slot about to be overwritten holds the oldest sample once the window is full
    assign oldest = mem[wptr];

    // Write pointer: cleared on flush, jumps to 1 on restart, otherwise advances per write
    always_ff @(posedge clk) begin
        if (flush) begin
            wptr <= '0;
        end else if (restart) begin
            wptr <= LOG2_DEPTH'(1);
        end else if (we) begin
            wptr <= wptr + 1'b1;
        end
    end

    // Sample storage is deliberately not reset; stale contents are never read before refill
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/rpm_period_averager.sv
// rtl/rpm_period_averager.sv - moving-average tooth-period filter; optional outlier reject via RPM_AVG_OUTLIER_REJECT_EN
module rpm_period_averager
    import rpm_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LOG2_DEPTH   = DEF_LOG2_DEPTH,
    parameter int SUM_WIDTH    = DEF_SUM_WIDTH,
    parameter int REJECT_LIMIT = DEF_REJECT_LIMIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_period,
    input  logic                  clear,
    output logic [SUM_WIDTH-1:0]  sum,
    output logic [WIDTH-1:0]      avg_period,
    output logic                  avg_valid,
    output logic [LOG2_DEPTH:0]   fill_count,
    output logic                  full,
    output logic                  reject
);

    localparam int                DEPTH     = 1 << LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH + 1)'(DEPTH);

    if (LOG2_DEPTH < 1 || LOG2_DEPTH > 6) begin : g_bad_depth
        $error("LOG2_DEPTH must be in 1..6");
    end
    if (SUM_WIDTH < min_sum_width(WIDTH, LOG2_DEPTH)) begin : g_bad_sum
        $error("SUM_WIDTH too narrow for WIDTH and LOG2_DEPTH");
    end
    if (REJECT_LIMIT < 1) begin : g_bad_limit
        $error("REJECT_LIMIT must be at least 1");
    end

    logic                 flush;
    logic                 take;
    logic                 accept;
    logic                 restart;
    logic                 avg_pend;
    logic [WIDTH-1:0]     oldest;
    logic [SUM_WIDTH-1:0] in_ext;
    logic [SUM_WIDTH-1:0] old_ext;
    logic [LOG2_DEPTH:0]  fill_next;

    // Reset and clear share one flush path, and clear beats a same-cycle sample
    assign flush     = reset | clear;
    assign take      = in_valid & ~flush;
    assign in_ext    = SUM_WIDTH'(in_period);
    assign old_ext   = SUM_WIDTH'(oldest);
    assign fill_next = fill_count + 1'b1;
    assign full      = (fill_count == DEPTH_CNT);

`ifdef RPM_AVG_OUTLIER_REJECT_EN
    localparam int RC_W = $clog2(REJECT_LIMIT + 1);

    logic [RC_W-1:0]      rej_cnt;
    logic [SUM_WIDTH-1:0] avg_now;
    logic                 outlier;
    logic                 last_strike;

    // Outlier band is judged against the live window mean before this sample lands
    assign avg_now     = sum >> LOG2_DEPTH;
    assign outlier     = full && (({1'b0, in_ext} > {avg_now, 1'b0}) || (in_ext < (avg_now >> 1)));
    assign last_strike = (rej_cnt == RC_W'(REJECT_LIMIT - 1));
    assign accept      = take & ~outlier;
    assign restart     = take & outlier & last_strike;

    // Count consecutive outliers; the limit-th one restarts the window instead of pulsing reject
    always_ff @(posedge clk) begin
        if (flush) begin
            rej_cnt <= '0;
            reject  <= 1'b0;
        end else begin
            reject <= take & outlier & ~last_strike;
            if (take) begin
                rej_cnt <= (outlier && !last_strike) ? rej_cnt + 1'b1 : '0;
            end
        end
    end
`else
    assign accept  = take;
    assign restart = 1'b0;
    assign reject  = 1'b0;
`endif

    rpm_avg_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk     (clk),
        .flush   (flush),
        .we      (accept | restart),
        .restart (restart),
        .wdata   (in_period),
        .oldest  (oldest)
    );

    // Running sum and fill level: add newest, drop oldest once the window is full
    always_ff @(posedge clk) begin
        if (flush) begin
            sum        <= '0;
            fill_count <= '0;
            avg_pend   <= 1'b0;
        end else begin
            avg_pend <= 1'b0;
            if (restart) begin
                sum        <= in_ext;
                fill_count <= (LOG2_DEPTH + 1)'(1);
            end else if (accept) begin
                if (full) begin
                    sum      <= sum + in_ext - old_ext;
                    avg_pend <= 1'b1;
                end else begin
                    sum        <= sum + in_ext;
                    fill_count <= fill_next;
                    avg_pend   <= (fill_next == DEPTH_CNT);
                end
            end
        end
    end

    // Second pipeline stage: latch the average one cycle after the sum settles
    always_ff @(posedge clk) begin
        if (flush) begin
            avg_period <= '0;
            avg_valid  <= 1'b0;
        end else begin
            avg_valid <= avg_pend;
            if (avg_pend) begin
                avg_period <= sum[LOG2_DEPTH +: WIDTH];
            end
        end
    end

endmodule
